// File: rtl/sdr_eth_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sdr_eth_pkg
//  Description : Shared Ethernet TX constants and the MAC TX arbiter state
//                type, used by the arbiter and the IQ packetizer.
//  Revision    : 1.0 - initial release
// ============================================================================
package sdr_eth_pkg;

  // Largest untagged Ethernet frame in bytes (beats on the byte stream)
  localparam int ETH_MAX_FRAME   = 1518;
  // Default inter-frame idle gap in clock cycles
  localparam int ETH_IFG_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2,
    GAP   = 2'd3
  } arb_state_t;

  // Port index (0/1) to one-hot grant vector
  function automatic logic [1:0] port_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mac_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mac_tx_arbiter_if
//  Description : Byte-wide AXI-Stream link (tdata/tvalid/tlast/tuser/tready)
//                between frame sources, the TX arbiter and the MAC.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mac_tx_arbiter_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tlast;
  logic       tuser;
  logic       tready;

  modport master (output tdata, output tvalid, output tlast, output tuser, input  tready);
  modport slave  (input  tdata, input  tvalid, input  tlast, input  tuser, output tready);
endinterface
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter2
//  Description : Two-request picker with a last-granted pointer. Round-robin
//                on ties, or port 0 always first when FIXED_PRIO is set.
//                The one-hot grant is registered on the take strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2
  import sdr_eth_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic [1:0] i_req,
  input  wire logic       i_take,
  output logic      [1:0] o_grant
);

  logic       r_last;   // index of the most recently granted port
  logic [1:0] r_grant;
  logic       w_win;    // index of the winning port for the current requests

  // Pick the winner: a lone requester wins, a tie goes to priority or pointer
  always_comb begin
    w_win = 1'b0;
    if (i_req == 2'b10) begin
      w_win = 1'b1;
    end else if (i_req == 2'b11) begin
      w_win = (FIXED_PRIO != 0) ? 1'b0 : ~r_last;
    end
  end

  // Capture the grant and move the pointer whenever a grant is taken
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last  <= 1'b1;
      r_grant <= 2'b00;
    end else if (i_take) begin
      r_last  <= w_win;
      r_grant <= port_onehot(w_win);
    end
  end

  assign o_grant = r_grant;

endmodule
`default_nettype wire

// File: rtl/mac_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mac_tx_arbiter
//  Description : Frame-atomic arbiter sharing the MAC TX byte stream between
//                two sources, with an enforced inter-frame gap and forced
//                truncation of runaway frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_tx_arbiter
  import sdr_eth_pkg::*;
#(
  parameter int IFG_CYCLES      = ETH_IFG_DEFAULT,
  parameter int FIXED_PRIO      = 0,
  parameter int MAX_FRAME_BYTES = ETH_MAX_FRAME
) (
  input  wire logic        clk,
  input  wire logic        rst,
  mac_tx_arbiter_if.slave  s0,
  mac_tx_arbiter_if.slave  s1,
  mac_tx_arbiter_if.master m,
  output logic [1:0]       grant,
  output logic             busy,
  output logic             trunc_pulse
);

  localparam int CNT_W = $clog2(MAX_FRAME_BYTES + 1);
  localparam int GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  // Count value seen while the last permitted beat is on the bus
  localparam logic [CNT_W-1:0] c_trunc_at = CNT_W'(MAX_FRAME_BYTES - 1);
  localparam logic [GAP_W-1:0] c_gap_load = (IFG_CYCLES > 0) ? GAP_W'(IFG_CYCLES - 1) : '0;
  localparam arb_state_t       c_end_state = (IFG_CYCLES > 0) ? GAP : IDLE;

  arb_state_t       r_state;
  arb_state_t       w_next;
  logic [CNT_W-1:0] r_beat_cnt;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [1:0]       w_grant;
  logic [1:0]       w_req;
  logic             w_take;
  logic             w_sel;
  logic [7:0]       w_src_data;
  logic             w_src_valid, w_src_last, w_src_user;
  logic             w_at_limit, w_beat, w_drain_last;
  logic             w_s0_ready, w_s1_ready;
  logic [7:0]       w_m_data;
  logic             w_m_valid, w_m_last, w_m_user, w_trunc;

  assign w_req  = {s1.tvalid, s0.tvalid};
  assign w_take = (r_state == IDLE) && (w_req != 2'b00);

  rr_arbiter2 #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_rr (
    .clk     (clk),
    .rst     (rst),
    .i_req   (w_req),
    .i_take  (w_take),
    .o_grant (w_grant)
  );

  // Granted source selection; only meaningful outside IDLE
  assign w_sel        = w_grant[1];
  assign w_src_data   = w_sel ? s1.tdata  : s0.tdata;
  assign w_src_valid  = w_sel ? s1.tvalid : s0.tvalid;
  assign w_src_last   = w_sel ? s1.tlast  : s0.tlast;
  assign w_src_user   = w_sel ? s1.tuser  : s0.tuser;

  // A source tlast on the limit beat is a normal end of frame, not a truncation
  assign w_at_limit   = (r_beat_cnt == c_trunc_at) && !w_src_last;
  assign w_beat       = (r_state == XFER) && w_src_valid && m.tready;
  assign w_drain_last = (r_state == DRAIN) && w_src_valid && w_src_last;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic: grants only from IDLE, whole frames only
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_req != 2'b00) w_next = XFER;
      XFER:    if (w_beat) begin
                 if (w_src_last)      w_next = c_end_state;
                 else if (w_at_limit) w_next = DRAIN;
               end
      DRAIN:   if (w_drain_last) w_next = c_end_state;
      GAP:     if (r_gap_cnt == '0) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Output logic: everything gated by state so idle outputs are all zero
  always_comb begin
    w_m_data   = 8'h00;
    w_m_valid  = 1'b0;
    w_m_last   = 1'b0;
    w_m_user   = 1'b0;
    w_s0_ready = 1'b0;
    w_s1_ready = 1'b0;
    w_trunc    = 1'b0;
    case (r_state)
      XFER: begin
        w_m_data  = w_src_data;
        w_m_valid = w_src_valid;
        w_m_last  = w_src_last | w_at_limit;
        w_m_user  = w_src_user | w_at_limit;
        w_trunc   = w_beat & w_at_limit;
        if (w_sel) w_s1_ready = m.tready;
        else       w_s0_ready = m.tready;
      end
      DRAIN: begin
        if (w_sel) w_s1_ready = 1'b1;
        else       w_s0_ready = 1'b1;
      end
      default: ;
    endcase
  end

  // Frame beat counter, restarted on every grant
  always_ff @(posedge clk) begin
    if (rst)         r_beat_cnt <= '0;
    else if (w_take) r_beat_cnt <= '0;
    else if (w_beat) r_beat_cnt <= r_beat_cnt + CNT_W'(1);
  end

  // Inter-frame gap counter, loaded on entry to GAP
  always_ff @(posedge clk) begin
    if (rst)                                      r_gap_cnt <= '0;
    else if ((r_state != GAP) && (w_next == GAP)) r_gap_cnt <= c_gap_load;
    else if ((r_state == GAP) && (r_gap_cnt != '0)) r_gap_cnt <= r_gap_cnt - GAP_W'(1);
  end

  assign m.tdata     = w_m_data;
  assign m.tvalid    = w_m_valid;
  assign m.tlast     = w_m_last;
  assign m.tuser     = w_m_user;
  assign s0.tready   = w_s0_ready;
  assign s1.tready   = w_s1_ready;
  assign grant       = (r_state != IDLE) ? w_grant : 2'b00;
  assign busy        = (r_state != IDLE);
  assign trunc_pulse = w_trunc;

endmodule
`default_nettype wire

// File: doc/mac_tx_arbiter.md
# mac_tx_arbiter

Frame-atomic arbiter that shares the single Ethernet MAC transmit byte stream between two frame sources: port 0 (IQ packetizer) and port 1 (control/ARP/housekeeping). It grants whole frames with round-robin or fixed priority, enforces a minimum idle gap between frames, and truncates runaway frames so one source can never lock up the MAC. It sits between the frame generators and the MAC TX AXI-Stream input, all in the `clk` domain.

## Interface
- `IFG_CYCLES`, 16: idle cycles forced after each frame's last beat; 0 allowed.
- `FIXED_PRIO`, 0: 0 = round-robin; 1 = port 0 always wins a simultaneous request.
- `MAX_FRAME_BYTES`, 1518: beats allowed per frame before forced truncation; must be ≥ 2.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `s0_tdata`/`s1_tdata`  in  8  source byte.
- `s0_tvalid`/`s1_tvalid`  in  1  source beat valid.
- `s0_tlast`/`s1_tlast`  in  1  last beat of frame.
- `s0_tuser`/`s1_tuser`  in  1  source abort flag; meaningful with tlast.
- `s0_tready`/`s1_tready`  out  1  beat accepted from source.
- `m_tdata`  out  8  byte to MAC.
- `m_tvalid`  out  1  beat valid to MAC.
- `m_tlast`  out  1  last beat to MAC.
- `m_tuser`  out  1  abort frame at MAC.
- `m_tready`  in  1  MAC ready.
- `grant`  out  2  one-hot current owner; 00 when none.
- `busy`  out  1  state ≠ IDLE.
- `trunc_pulse`  out  1  one-cycle pulse when a frame is truncated.

## Operation
- States: IDLE, XFER, DRAIN, GAP.
- IDLE: all treadys 0, `m_tvalid` 0. If either `sN_tvalid` is 1, register the winner into `grant` and go to XFER.
  - Round-robin: the port not most recently granted wins. The `last` pointer resets to 1, so port 0 wins the first tie. The pointer updates on every grant.
- XFER: combinational pass-through of the granted port: `m_tdata/tvalid/tlast/tuser` = `sN_*`, `sN_tready` = `m_tready`. The non-granted tready is 0.
  - A beat is one cycle with `m_tvalid & m_tready`. Each beat increments `beat_cnt` (width `$clog2(MAX_FRAME_BYTES+1)`, cleared on grant).
  - Beat with tlast: go to GAP, or to IDLE if `IFG_CYCLES`=0.
  - Beat number `MAX_FRAME_BYTES` with source tlast=0: drive `m_tlast`=1 and `m_tuser`=1 on that beat, pulse `trunc_pulse`, go to DRAIN.
- DRAIN: `m_tvalid`=0. Granted `sN_tready`=1 and its beats are discarded. On a discarded beat with tlast, go to GAP (or IDLE if `IFG_CYCLES`=0).
- GAP: load `gap_cnt`=`IFG_CYCLES`-1 on entry. Decrement each cycle; at 0 go to IDLE. Outputs are idle and `grant` is held.
- Source tuser is forwarded unmodified. The arbiter does not inspect frame contents.

## Timing
- Reset values: `grant`=00, `busy`=0, `trunc_pulse`=0, all treadys 0, `m_tvalid`=`m_tlast`=`m_tuser`=0, `m_tdata`=0 (outputs are gated by state). State=IDLE, `last`=1, counters 0.
- Arbitration latency: source tvalid seen in IDLE at cycle t → first beat can transfer at t+1.
- Datapath latency is 0 (combinational mux). `m_tvalid` depends only on the state register and the source tvalid, never on `m_tready`.
- Frame-to-frame: last beat at cycle t → IDLE at t+`IFG_CYCLES`+1 → next first beat no earlier than t+`IFG_CYCLES`+2.
- A request that arrives during XFER/DRAIN/GAP waits; a new grant happens only in IDLE.
- Backpressure: `m_tready`=0 stalls the granted source with its beat held. `beat_cnt` does not advance.
- Simultaneous truncation beat and source tlast: treated as a normal tlast, no truncation.
- `rst` asserted mid-frame: next cycle all outputs are at reset values. The MAC shares `rst` and discards its partial frame. Sources re-request from their frame start.

## Structure
- Package `sdr_eth_pkg`: state enum (IDLE, XFER, DRAIN, GAP), `ETH_MAX_FRAME` = 1518, `ETH_IFG_DEFAULT` = 16. The packetizer uses the same constants.
- Sub-module `rr_arbiter2`: a 2-request, 1-hot-grant picker with a `last` pointer and a `FIXED_PRIO` parameter, registered on a `take` strobe.

## Test plan
- Only s0 sends a 60-byte frame with `m_tready`=1 → 60 beats on m, `grant`=01, tlast on beat 60, `busy` low 17 cycles after the last beat.
- s0 and s1 request together, 3 frames each, round-robin → grant order s0,s1,s0,s1,s0,s1. With `FIXED_PRIO`=1 and s0 always requesting → s1 never granted.
- Gap check: back-to-back 64-byte frames on s1, `IFG_CYCLES`=16 → exactly 17 cycles between last beat and next first beat. With `IFG_CYCLES`=0 → 1 cycle.
- Random `m_tready` (50%) on a 100-byte frame → byte sequence intact, no duplicates or drops, and `sN_tready` equals `m_tready` throughout.
- `MAX_FRAME_BYTES`=32, s0 sends 40 bytes → 32 m beats, beat 32 has tlast=1 and tuser=1, one `trunc_pulse`, 8 source bytes drained with `m_tvalid`=0, then GAP.
- `rst` pulsed at beat 10 of a 60-byte frame → next cycle `m_tvalid`=0 and `grant`=00. A fresh s1 frame afterwards wins first (pointer reset).
